pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 114 +++++++++++
 tb/tb_pipe_skid_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with skid buffer, flush, and a saturating drop counter.
// o_ready is registered, so there is no combinational path from i_ready back to upstream.
module pipe_skid_reg #(
  parameter int                CTRL_W      = 14,
  parameter int                DATA_W      = 143,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}},
  parameter int                CNT_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_drop_cnt
);

  typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} state_t;

  state_t              state_p0;
  logic                vld_p0;
  logic                rdy_p0;
  logic [CTRL_W-1:0]   main_ctrl_p0;
  logic [DATA_W-1:0]   main_data_p0;
  logic [CTRL_W-1:0]   skid_ctrl_p0;
  logic [DATA_W-1:0]   skid_data_p0;
  logic [CNT_W-1:0]    drop_cnt_p0;

  logic                accept;
  logic                xfer;
  logic [1:0]          held;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       n);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(n);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign accept = i_valid & rdy_p0;
  assign xfer   = vld_p0 & i_ready;
  assign held   = (state_p0 == ST_FULL) ? 2'd2 :
                  (state_p0 == ST_BUSY) ? 2'd1 : 2'd0;

  // Main/skid entries: state, valid and ready all move together on one edge
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_p0     <= ST_EMPTY;
      vld_p0       <= 1'b0;
      rdy_p0       <= 1'b1;
      main_ctrl_p0 <= '0;
      main_data_p0 <= '0;
      skid_ctrl_p0 <= '0;
      skid_data_p0 <= '0;
      drop_cnt_p0  <= '0;
    end else if (i_flush) begin
      state_p0    <= ST_EMPTY;
      vld_p0      <= 1'b0;
      rdy_p0      <= 1'b1;
      drop_cnt_p0 <= sat_add(drop_cnt_p0, held);
    end else begin
      case (state_p0)
        ST_EMPTY: begin
          if (accept) begin
            main_ctrl_p0 <= i_ctrl;
            main_data_p0 <= i_data;
            vld_p0       <= 1'b1;
            state_p0     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept && xfer) begin
            main_ctrl_p0 <= i_ctrl;
            main_data_p0 <= i_data;
          end else if (xfer) begin
            vld_p0   <= 1'b0;
            state_p0 <= ST_EMPTY;
          end else if (accept) begin
            // Downstream stalled: park the new beat so upstream never sees a combinational stall
            skid_ctrl_p0 <= i_ctrl;
            skid_data_p0 <= i_data;
            rdy_p0       <= 1'b0;
            state_p0     <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            main_ctrl_p0 <= skid_ctrl_p0;
            main_data_p0 <= skid_data_p0;
            rdy_p0       <= 1'b1;
            state_p0     <= ST_BUSY;
          end
        end
        default: begin
          state_p0 <= ST_EMPTY;
          vld_p0   <= 1'b0;
          rdy_p0   <= 1'b1;
        end
      endcase
    end
  end

  assign o_valid    = vld_p0;
  assign o_ready    = rdy_p0;
  assign o_ctrl     = vld_p0 ? main_ctrl_p0 : BUBBLE_CTRL;
  assign o_data     = main_data_p0;
  assign o_drop_cnt = drop_cnt_p0;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed scenarios plus randomized valid/ready/flush/reset.
module tb_pipe_skid_reg;
  localparam int CW = 14;
  localparam int DW = 143;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_valid = 1'b0;
  logic [CW-1:0] i_ctrl = '0;
  logic [DW-1:0] i_data = '0;
  logic          i_flush = 1'b0;
  logic          i_ready = 1'b0;

  logic          o_ready, o_valid;
  logic [CW-1:0] o_ctrl;
  logic [DW-1:0] o_data;
  logic [15:0]   o_drop_cnt;

  logic          o_ready2, o_valid2;
  logic [CW-1:0] o_ctrl2;
  logic [DW-1:0] o_data2;
  logic [1:0]    o_drop_cnt2;

  int n_cmp = 0;
  int n_err = 0;
  int drops = 0;
  int seq   = 0;
  beat_t hq[$];     // beats the stage should currently hold, oldest first
  beat_t acc_q[$];  // beats accepted this cycle, merged by the monitor

  always #5 clk = ~clk;

  pipe_skid_reg dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_ctrl(i_ctrl), .i_data(i_data), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_ctrl(o_ctrl), .o_data(o_data), .o_drop_cnt(o_drop_cnt)
  );

  pipe_skid_reg #(.CNT_W(2)) dut_sat (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready2),
    .i_ctrl(i_ctrl), .i_data(i_data), .i_flush(i_flush), .o_valid(o_valid2),
    .i_ready(i_ready), .o_ctrl(o_ctrl2), .o_data(o_data2), .o_drop_cnt(o_drop_cnt2)
  );

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One input cycle: drive after the edge, record acceptance before the next edge
  task automatic cyc(input logic v, input logic [CW-1:0] c, input logic rdy,
                     input logic fl, input logic rst);
    logic [159:0] r;
    beat_t b;
    @(posedge clk);
    #1;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    r[31:0] = 32'(seq);
    seq++;
    b.c = c;
    b.d = r[DW-1:0];
    i_valid = v;
    i_ctrl  = c;
    i_data  = b.d;
    i_ready = rdy;
    i_flush = fl;
    i_reset = rst;
    #2;
    if (v && o_ready && !fl && !rst) acc_q.push_back(b);
  endtask

  task automatic fill_two(input logic [CW-1:0] a, input logic [CW-1:0] b);
    cyc(1'b1, a, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, b, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare outputs against the held-beat model, then apply this cycle's events
  initial begin
    int held;
    int sat;
    @(posedge clk);
    forever begin
      @(negedge clk);
      held = hq.size();
      sat  = (drops > 3) ? 3 : drops;
      chk("o_valid", 160'(o_valid), 160'(held > 0));
      chk("o_ready", 160'(o_ready), 160'(held < 2));
      chk("o_valid_sat", 160'(o_valid2), 160'(held > 0));
      chk("o_ready_sat", 160'(o_ready2), 160'(held < 2));
      if (held > 0) begin
        chk("o_ctrl", 160'(o_ctrl), 160'(hq[0].c));
        chk("o_data", 160'(o_data), 160'(hq[0].d));
        chk("o_ctrl_sat", 160'(o_ctrl2), 160'(hq[0].c));
        chk("o_data_sat", 160'(o_data2), 160'(hq[0].d));
      end else begin
        chk("o_ctrl_bubble", 160'(o_ctrl), 160'(0));
        chk("o_ctrl_bubble_sat", 160'(o_ctrl2), 160'(0));
      end
      chk("o_drop_cnt", 160'(o_drop_cnt), 160'(drops[15:0]));
      chk("o_drop_cnt_sat", 160'(o_drop_cnt2), 160'(sat));
      if (i_reset) begin
        hq.delete();
        drops = 0;
      end else if (i_flush) begin
        drops += held;
        hq.delete();
      end else if (held > 0 && i_ready) begin
        void'(hq.pop_front());
      end
      while (acc_q.size() > 0) hq.push_back(acc_q.pop_front());
      if (hq.size() > 2) begin
        n_cmp++;
        n_err++;
        $display("FAIL occupancy: got %0d beats held expected at most 2", hq.size());
        hq.delete();
      end
    end
  end

  initial begin
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // Streaming with downstream always ready
    for (int k = 1; k <= 5; k++) cyc(1'b1, CW'(k), 1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // Fill to FULL, ignored third beat, then drain
    fill_two(CW'('h11), CW'('h22));
    cyc(1'b1, CW'('h33), 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // Flush of FULL with a beat offered in the same cycle
    fill_two(CW'('h11), CW'('h22));
    cyc(1'b1, CW'('h44), 1'b0, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // Four more flushes of FULL: narrow counter saturates
    for (int k = 0; k < 4; k++) begin
      fill_two(CW'(k + 'h100), CW'(k + 'h200));
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // Reset beats flush in BUSY: counter clears, nothing held
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, CW'('h55), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, CW'('h66), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // Randomized traffic
    for (int k = 0; k < 10000; k++) begin
      cyc(($urandom % 4) != 0, CW'($urandom), ($urandom % 3) != 0,
          ($urandom % 40) == 0, ($urandom % 1500) == 0);
    end
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
